// File: rtl/jenc_pkg.sv
// Shared constants and types for the encoder frame builder.
// Frame byte offsets must match the receiver's field latching.
package jenc_pkg;

    localparam int unsigned PKT_LEN  = 38;
    localparam int unsigned RAW_BITS = 14;
    localparam int unsigned IDX_W    = 6;

    localparam logic [IDX_W-1:0] OFS_SEQ    = 6'd0;
    localparam logic [IDX_W-1:0] OFS_USECS  = 6'd4;
    localparam logic [IDX_W-1:0] OFS_STATUS = 6'd8;
    localparam logic [IDX_W-1:0] OFS_ANGLE  = 6'd16;
    localparam logic [IDX_W-1:0] OFS_VEL    = 6'd20;
    localparam logic [IDX_W-1:0] OFS_RAW    = 6'd32;
    localparam logic [IDX_W-1:0] OFS_CSUM   = 6'd36;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_LEN - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

endpackage

// File: rtl/jenc_byte_sel.sv
// Combinational map from frame byte index to byte value.
// Every field sits on a 4-byte boundary, so the upper index bits pick the word.
module jenc_byte_sel
    import jenc_pkg::*;
(
    input  logic [IDX_W-1:0]    i_idx,
    input  logic [15:0]         i_seq,
    input  logic [31:0]         i_usecs,
    input  logic [31:0]         i_status,
    input  logic [31:0]         i_angle,
    input  logic [31:0]         i_vel,
    input  logic [RAW_BITS-1:0] i_raw,
    input  logic [15:0]         i_csum,
    output logic [7:0]          o_byte
);

    logic [31:0] w_word;

    always_comb begin
        w_word = '0;
        case (i_idx[IDX_W-1:2])
            OFS_SEQ[IDX_W-1:2]:    w_word = {16'h0, i_seq};
            OFS_USECS[IDX_W-1:2]:  w_word = i_usecs;
            OFS_STATUS[IDX_W-1:2]: w_word = i_status;
            OFS_ANGLE[IDX_W-1:2]:  w_word = i_angle;
            OFS_VEL[IDX_W-1:2]:    w_word = i_vel;
            OFS_RAW[IDX_W-1:2]:    w_word = {16'h0, {(16 - RAW_BITS){1'b0}}, i_raw};
            OFS_CSUM[IDX_W-1:2]:   w_word = {16'h0, i_csum};
            default:               w_word = '0;
        endcase
    end

    assign o_byte = w_word[{i_idx[1:0], 3'b000} +: 8];

endmodule

// File: rtl/jenc_reg.sv
// Enabled register with synchronous active-high reset to zero.
module jenc_reg #(
    parameter int unsigned W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_en,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/jenc_framer.sv
// Snapshots one encoder sample and streams it as a 38-byte little-endian frame.
// txd is computed one cycle ahead from next-state index/fields so byte 0 is ready at t+1.
module jenc_framer
    import jenc_pkg::*;
(
    input  logic                i_c,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic [31:0]         i_usecs,
    input  logic [31:0]         i_angle,
    input  logic [31:0]         i_vel,
    input  logic [RAW_BITS-1:0] i_raw,
    input  logic [31:0]         i_status,
    output logic [7:0]          o_txd,
    output logic                o_txdv,
    input  logic                i_txr,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_overrun,
    output logic [15:0]         o_seq
);

    state_t r_state;
    state_t w_state_nxt;

    logic w_start_ok;
    logic w_xfer;
    logic w_last;
    logic w_csum_add;

    logic [31:0]         r_usecs, r_angle, r_vel, r_status;
    logic [RAW_BITS-1:0] r_raw;
    logic [15:0]         r_seq_snap, r_seq, r_csum;
    logic [IDX_W-1:0]    r_idx;
    logic [7:0]          r_txd;
    logic                r_done, r_overrun;

    logic [IDX_W-1:0]    w_idx_d;
    logic [15:0]         w_csum_d;
    logic [31:0]         w_usecs_d, w_angle_d, w_vel_d, w_status_d;
    logic [RAW_BITS-1:0] w_raw_d;
    logic [15:0]         w_seq_snap_d;
    logic [7:0]          w_byte;

    always_ff @(posedge i_c) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start_ok  = 1'b0;
        w_xfer      = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_start_ok  = 1'b1;
                    w_state_nxt = SEND;
                end
            end
            SEND: begin
                w_xfer = i_txr;
                w_last = i_txr && (r_idx == LAST_IDX);
                if (w_last) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Only bytes 0..35 feed the checksum; the checksum bytes themselves do not.
    assign w_csum_add = w_xfer && (r_idx < OFS_CSUM);

    assign w_idx_d      = w_start_ok ? '0 : r_idx + IDX_W'(1);
    assign w_csum_d     = w_start_ok ? 16'h0 :
                          (w_csum_add ? r_csum + {8'h0, r_txd} : r_csum);
    assign w_usecs_d    = w_start_ok ? i_usecs  : r_usecs;
    assign w_angle_d    = w_start_ok ? i_angle  : r_angle;
    assign w_vel_d      = w_start_ok ? i_vel    : r_vel;
    assign w_status_d   = w_start_ok ? i_status : r_status;
    assign w_raw_d      = w_start_ok ? i_raw    : r_raw;
    assign w_seq_snap_d = w_start_ok ? r_seq    : r_seq_snap;

    jenc_reg #(.W(32)) u_usecs (
        .i_clk(i_c), .i_rst(i_rst), .i_en(w_start_ok), .i_d(i_usecs), .o_q(r_usecs)
    );
    jenc_reg #(.W(32)) u_angle (
        .i_clk(i_c), .i_rst(i_rst), .i_en(w_start_ok), .i_d(i_angle), .o_q(r_angle)
    );
    jenc_reg #(.W(32)) u_vel (
        .i_clk(i_c), .i_rst(i_rst), .i_en(w_start_ok), .i_d(i_vel), .o_q(r_vel)
    );
    jenc_reg #(.W(32)) u_status (
        .i_clk(i_c), .i_rst(i_rst), .i_en(w_start_ok), .i_d(i_status), .o_q(r_status)
    );
    jenc_reg #(.W(RAW_BITS)) u_raw (
        .i_clk(i_c), .i_rst(i_rst), .i_en(w_start_ok), .i_d(i_raw), .o_q(r_raw)
    );
    jenc_reg #(.W(16)) u_seq_snap (
        .i_clk(i_c), .i_rst(i_rst), .i_en(w_start_ok), .i_d(r_seq), .o_q(r_seq_snap)
    );
    jenc_reg #(.W(IDX_W)) u_idx (
        .i_clk(i_c), .i_rst(i_rst), .i_en(w_start_ok | w_xfer), .i_d(w_idx_d), .o_q(r_idx)
    );
    jenc_reg #(.W(16)) u_csum (
        .i_clk(i_c), .i_rst(i_rst), .i_en(w_start_ok | w_csum_add), .i_d(w_csum_d),
        .o_q(r_csum)
    );
    jenc_reg #(.W(16)) u_seq (
        .i_clk(i_c), .i_rst(i_rst), .i_en(w_last), .i_d(r_seq + 16'd1), .o_q(r_seq)
    );

    jenc_byte_sel u_byte_sel (
        .i_idx    (w_idx_d),
        .i_seq    (w_seq_snap_d),
        .i_usecs  (w_usecs_d),
        .i_status (w_status_d),
        .i_angle  (w_angle_d),
        .i_vel    (w_vel_d),
        .i_raw    (w_raw_d),
        .i_csum   (w_csum_d),
        .o_byte   (w_byte)
    );

    always_ff @(posedge i_c) begin
        if (i_rst) begin
            r_txd     <= 8'h00;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_start_ok || w_xfer) begin
                r_txd <= w_byte;
            end
            r_done    <= w_last;
            r_overrun <= i_start && (r_state == SEND);
        end
    end

    assign o_txd     = r_txd;
    assign o_txdv    = (r_state == SEND);
    assign o_busy    = (r_state == SEND);
    assign o_done    = r_done;
    assign o_overrun = r_overrun;
    assign o_seq     = r_seq;

endmodule

// File: tb/tb_jenc_framer.sv
// Directed bench for jenc_framer; inputs driven and outputs sampled on the falling edge.
module tb_jenc_framer;

    localparam int PKT = 38;
    typedef logic [7:0] frame_t [PKT];

    logic        clk = 1'b0;
    logic        rst, start, txr;
    logic [31:0] usecs, angle, vel, status;
    logic [13:0] raw;
    logic [7:0]  txd;
    logic        txdv, busy, done, overrun;
    logic [15:0] seq;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    jenc_framer dut (
        .i_c       (clk),
        .i_rst     (rst),
        .i_start   (start),
        .i_usecs   (usecs),
        .i_angle   (angle),
        .i_vel     (vel),
        .i_raw     (raw),
        .i_status  (status),
        .o_txd     (txd),
        .o_txdv    (txdv),
        .i_txr     (txr),
        .o_busy    (busy),
        .o_done    (done),
        .o_overrun (overrun),
        .o_seq     (seq)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic frame_t model(input logic [15:0] s, input logic [31:0] us,
                                     input logic [31:0] st, input logic [31:0] an,
                                     input logic [31:0] ve, input logic [13:0] rw);
        frame_t      f;
        logic [31:0] sw;
        logic [15:0] sum;
        f  = '{default: 8'h00};
        sw = {16'h0, s};
        for (int i = 0; i < 4; i++) begin
            f[0 + i]  = 8'(sw >> (8 * i));
            f[4 + i]  = 8'(us >> (8 * i));
            f[8 + i]  = 8'(st >> (8 * i));
            f[16 + i] = 8'(an >> (8 * i));
            f[20 + i] = 8'(ve >> (8 * i));
        end
        f[32] = rw[7:0];
        f[33] = {2'b00, rw[13:8]};
        sum = 16'h0;
        for (int i = 0; i < 36; i++) sum = sum + {8'h00, f[i]};
        f[36] = sum[7:0];
        f[37] = sum[15:8];
        return f;
    endfunction

    task automatic set_inputs(input logic [31:0] us, input logic [31:0] an,
                              input logic [31:0] ve, input logic [13:0] rw,
                              input logic [31:0] st);
        usecs = us; angle = an; vel = ve; raw = rw; status = st;
    endtask

    task automatic check_frame(input string name, input frame_t got, input frame_t exp);
        for (int i = 0; i < PKT; i++) check($sformatf("%s_b%0d", name, i), got[i], exp[i]);
    endtask

    // Starts a frame and collects it; optional overrun start or reset at a given byte index.
    task automatic run_frame(input bit bp, input int ovr_at, input int rst_at,
                             output frame_t got, output int n_ovr);
        int         n, cyc;
        bit         stalled, ovr_fired, t;
        logic [7:0] last_txd;
        n = 0; cyc = 0; stalled = 0; ovr_fired = 0; n_ovr = 0; last_txd = 8'h00;
        got = '{default: 8'h00};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("done_clr", done, 1'b0);
        while (n < PKT && cyc < 1000) begin
            check("txdv_hi", txdv, 1'b1);
            check("busy_hi", busy, 1'b1);
            if (stalled) check("txd_hold", txd, last_txd);
            if (overrun) n_ovr++;
            if (n == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check("rst_txdv", txdv, 1'b0);
                check("rst_busy", busy, 1'b0);
                check("rst_seq", seq, 16'h0);
                check("rst_txd", txd, 8'h00);
                check("rst_done", done, 1'b0);
                check("rst_ovr", overrun, 1'b0);
                return;
            end
            if (n == ovr_at && !ovr_fired) begin
                ovr_fired = 1;
                start = 1'b1;
                set_inputs(32'hDEADBEEF, 32'h0BADF00D, 32'h12345678, 14'h0123, 32'hCAFEBABE);
            end else begin
                start = 1'b0;
            end
            t = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            txr = t;
            if (txdv && t) begin
                got[n] = txd;
                n++;
                stalled = 0;
            end else begin
                stalled = 1;
                last_txd = txd;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        txr = 1'b1;
        if (cyc >= 1000) check("timeout", n, PKT);
        if (overrun) n_ovr++;
        check("done_pulse", done, 1'b1);
        check("end_txdv", txdv, 1'b0);
        check("end_busy", busy, 1'b0);
    endtask

    frame_t got;
    int     novr;

    initial begin
        rst = 1'b1; start = 1'b0; txr = 1'b1;
        set_inputs(32'h11223344, 32'hAABBCCDD, 32'h01020304, 14'h3FFF, 32'h5A5A0001);
        repeat (3) @(negedge clk);
        check("rst_txdv0", txdv, 1'b0);
        check("rst_busy0", busy, 1'b0);
        check("rst_done0", done, 1'b0);
        check("rst_ovr0", overrun, 1'b0);
        check("rst_seq0", seq, 16'h0);
        check("rst_txd0", txd, 8'h00);

        // Reset and start together: reset must win.
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check("rst_wins", busy, 1'b0);
        @(negedge clk);
        check("idle_busy", busy, 1'b0);

        // Frame A, txr held high.
        run_frame(0, -1, -1, got, novr);
        check_frame("A", got, model(16'h0, 32'h11223344, 32'h5A5A0001, 32'hAABBCCDD,
                                    32'h01020304, 14'h3FFF));
        check("A_b4", got[4], 8'h44);
        check("A_b7", got[7], 8'h11);
        check("A_b16", got[16], 8'hDD);
        check("A_b23", got[23], 8'h01);
        check("A_b32", got[32], 8'hFF);
        check("A_b33", got[33], 8'h3F);
        check("A_csum_lo", got[36], 8'hB5);
        check("A_csum_hi", got[37], 8'h05);
        check("A_ovr", novr, 0);
        check("A_seq", seq, 16'd1);

        // Frame B back-to-back, all-ones fields.
        set_inputs(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 14'h3FFF, 32'hFFFFFFFF);
        run_frame(0, -1, -1, got, novr);
        check("B_b0", got[0], 8'h01);
        check("B_b1", got[1], 8'h00);
        check("B_csum_lo", got[36], 8'h2F);
        check("B_csum_hi", got[37], 8'h11);
        check_frame("B", got, model(16'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                    32'hFFFFFFFF, 14'h3FFF));
        check("B_seq", seq, 16'd2);
        @(negedge clk);

        // Frame C with random backpressure.
        set_inputs(32'h11223344, 32'hAABBCCDD, 32'h01020304, 14'h3FFF, 32'h5A5A0001);
        run_frame(1, -1, -1, got, novr);
        check_frame("C", got, model(16'd2, 32'h11223344, 32'h5A5A0001, 32'hAABBCCDD,
                                    32'h01020304, 14'h3FFF));
        check("C_seq", seq, 16'd3);
        @(negedge clk);

        // Frame D: second start at byte 10 with changed inputs.
        set_inputs(32'h11223344, 32'hAABBCCDD, 32'h01020304, 14'h3FFF, 32'h5A5A0001);
        run_frame(1, 10, -1, got, novr);
        check("D_ovr", novr, 1);
        check_frame("D", got, model(16'd3, 32'h11223344, 32'h5A5A0001, 32'hAABBCCDD,
                                    32'h01020304, 14'h3FFF));
        check("D_seq", seq, 16'd4);
        @(negedge clk);

        // Frame E abandoned by reset at byte 20, then frame F restarts cleanly.
        set_inputs(32'h11223344, 32'hAABBCCDD, 32'h01020304, 14'h3FFF, 32'h5A5A0001);
        run_frame(0, -1, 20, got, novr);
        @(negedge clk);
        run_frame(0, -1, -1, got, novr);
        check("F_b0", got[0], 8'h00);
        check("F_csum_lo", got[36], 8'hB5);
        check("F_csum_hi", got[37], 8'h05);
        check_frame("F", got, model(16'd0, 32'h11223344, 32'h5A5A0001, 32'hAABBCCDD,
                                    32'h01020304, 14'h3FFF));
        check("F_seq", seq, 16'd1);
        @(negedge clk);

        // Sequence wrap: preload the counter rather than sending 65535 frames.
        force dut.u_seq.r_q = 16'hFFFF;
        #1;
        release dut.u_seq.r_q;
        @(negedge clk);
        run_frame(0, -1, -1, got, novr);
        check("W_b0", got[0], 8'hFF);
        check("W_b1", got[1], 8'hFF);
        check("W_csum_lo", got[36], 8'hB3);
        check("W_csum_hi", got[37], 8'h07);
        check_frame("W", got, model(16'hFFFF, 32'h11223344, 32'h5A5A0001, 32'hAABBCCDD,
                                    32'h01020304, 14'h3FFF));
        check("W_seq_wrap", seq, 16'h0);
        @(negedge clk);
        check("W_done_clr", done, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
